text_uart_tx: RTL and testbench



---
 rtl/text_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_text_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_uart_tx.sv
// Dumps the display text buffer over a UART TX line as 8N1 frames on a start pulse.
// Optional CR LF tail after the buffer contents when TEXT_TX_CRLF_EN is defined.
module text_uart_tx #(
    parameter int unsigned CLK_FREQ  = 12000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned MSG_LEN   = 16
) (
    input  logic       clk_in,
    input  logic       nrst,
    input  logic       start,
    output logic [3:0] buf_addr,
    input  logic [7:0] buf_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = 5;
`ifdef TEXT_TX_CRLF_EN
    localparam int unsigned N_FRAMES = MSG_LEN + 2;
`else
    localparam int unsigned N_FRAMES = MSG_LEN;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       addr_q, addr_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0]       frame_byte;
    logic             baud_end;

    assign baud_end = (baud_q == CNT_W'(DIV - 1));

    // Byte to load in FETCH: buffer contents, or the CR/LF tail past the buffer.
    always_comb begin
        frame_byte = buf_data;
`ifdef TEXT_TX_CRLF_EN
        if (idx_q == IDX_W'(MSG_LEN)) begin
            frame_byte = 8'h0D;
        end else if (idx_q == IDX_W'(MSG_LEN + 1)) begin
            frame_byte = 8'h0A;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end

            S_FETCH: begin
                shift_d = frame_byte;
                baud_d  = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end

            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            // tx is registered, so the next bit is presented from shift_q[1] as we shift.
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q < IDX_W'(N_FRAMES - 1)) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                        if (idx_q < IDX_W'(MSG_LEN - 1)) begin
                            addr_d = 4'(idx_q + IDX_W'(1));
                        end
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign buf_addr = addr_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_text_uart_tx.sv
// Bench for text_uart_tx: frame-level waveform model, UART decoder and literal timing checks.
module tb_text_uart_tx;

    localparam int DIV     = 8;
    localparam int MSG_LEN = 16;
    localparam int FRAME   = 1 + 10 * DIV;
`ifdef TEXT_TX_CRLF_EN
    localparam int NF = MSG_LEN + 2;
`else
    localparam int NF = MSG_LEN;
`endif
    localparam int EXP_DONE = 1 + NF * FRAME;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] buf_addr;
    logic [7:0] buf_data;
    logic       tx, busy, done;

    logic [7:0] mem [16];
    logic       use_rand = 1'b0;
    logic [7:0] rand_byte = 8'h00;

    assign buf_data = use_rand ? rand_byte : mem[buf_addr];

    text_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .MSG_LEN(MSG_LEN)) dut (
        .clk_in(clk), .nrst(nrst), .start(start), .buf_addr(buf_addr),
        .buf_data(buf_data), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic start_s;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) start_s <= 1'b0;
        else       start_s <= start;
    end

    // Model state: c counts cycles since the accepted start edge (c=0 is the first FETCH cycle).
    logic       active = 1'b0;
    int         c = 0;
    int         start_cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] mdl_byte = 8'h00;
    logic [7:0] rx_q [$];
    logic       rx_busy = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = 8'h00;
    logic       prev_tx = 1'b1;

    always @(negedge clk) begin
        logic prev_idle;
        logic e_tx, e_busy, e_done;
        int f, pos;
        if (!nrst) begin
            active  = 1'b0;
            rx_busy = 1'b0;
            prev_tx = 1'b1;
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_addr", 32'(buf_addr), 32'd0);
        end else begin
            prev_idle = !active || (c == NF * FRAME + 1);
            if (prev_idle && start_s) begin
                active    = 1'b1;
                c         = 0;
                start_cyc = cyc;
            end else if (active) begin
                c++;
                if (c > NF * FRAME + 1) active = 1'b0;
            end

            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            if (active) begin
                f   = c / FRAME;
                pos = c % FRAME;
                if (f < NF) begin
                    if (pos == 0)
                        mdl_byte = (f < MSG_LEN) ? mem[f] : ((f == MSG_LEN) ? 8'h0D : 8'h0A);
                    if (pos == 0)       e_tx = 1'b1;
                    else if (pos <= DIV) e_tx = 1'b0;
                    else if (pos <= 9 * DIV) e_tx = mdl_byte[3'((pos - 1 - DIV) / DIV)];
                    else                e_tx = 1'b1;
                    e_busy = 1'b1;
                    if (f < MSG_LEN) check("addr", 32'(buf_addr), 32'(f));
                end else if (c == NF * FRAME) begin
                    e_busy = 1'b1;
                end else begin
                    e_done = 1'b1;
                end
            end
            check("tx", 32'(tx), 32'(e_tx));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));

            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end

            // Independent 8N1 receiver, sampling mid-bit.
            if (!rx_busy && tx == 1'b0 && prev_tx == 1'b1) begin
                rx_busy = 1'b1;
                rx_t    = 0;
            end else if (rx_busy) begin
                rx_t++;
                if (rx_t >= DIV + DIV / 2 && rx_t < 9 * DIV + DIV / 2 && (rx_t - DIV / 2) % DIV == 0)
                    rx_sh = {tx, rx_sh[7:1]};
                if (rx_t == 9 * DIV + DIV / 2) begin
                    check("rx_stop", 32'(tx), 32'd1);
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
            prev_tx = tx;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_c(input int k);
        while (cyc < start_cyc + k) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_cnt == 0) begin
            n_err++;
            n_checks++;
            $display("FAIL %s: no done within %0d cycles", name, n);
        end
    endtask

    task automatic load_arrow();
        logic [7:0] s [16];
        s = '{8'h41, 8'h52, 8'h52, 8'h4F, 8'h57, 8'h20, 8'h20, 8'h20,
              8'h41, 8'h52, 8'h52, 8'h4F, 8'h57, 8'h20, 8'h20, 8'h20};
        for (int i = 0; i < 16; i++) mem[i] = s[i];
    endtask

    initial begin
        load_arrow();
        #1 nrst = 1'b0;
        use_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            start     = 1'($urandom_range(0, 1));
            rand_byte = 8'($urandom);
        end
        start    = 1'b0;
        use_rand = 1'b0;
        @(posedge clk); #2 nrst = 1'b1;
        repeat (4) @(posedge clk);

        // Dump with a mid-dump start pulse and a buffer change during frame 3.
        rx_q.delete();
        done_cnt = 0;
        pulse_start();
        wait_c(1); #1;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_c(2 * FRAME + 20);
        mem[2] = 8'h78;
        mem[3] = 8'h5A;
        wait_c(4 * FRAME + 26);
        pulse_start();
        wait_done("dump1");
        repeat (6) @(posedge clk);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_time", 32'(done_cyc - start_cyc), 32'(EXP_DONE));
        check("frame_count", 32'(rx_q.size()), 32'(NF));
        if (rx_q.size() == NF) begin
            check("frame1", 32'(rx_q[0]), 32'h41);
            check("frame2", 32'(rx_q[1]), 32'h52);
            check("frame3_latched", 32'(rx_q[2]), 32'h52);
            check("frame4_new", 32'(rx_q[3]), 32'h5A);
            check("frame16", 32'(rx_q[15]), 32'h20);
`ifdef TEXT_TX_CRLF_EN
            check("frame17_cr", 32'(rx_q[16]), 32'h0D);
            check("frame18_lf", 32'(rx_q[17]), 32'h0A);
`endif
        end

        // Reset in the middle of frame 2 DATA bit 4, then a clean dump.
        load_arrow();
        pulse_start();
        wait_c(FRAME + 9 + 4 * DIV + 2);
        #1 nrst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #2 nrst = 1'b1;
        repeat (3) @(posedge clk);
        rx_q.delete();
        done_cnt = 0;
        pulse_start();
        wait_done("dump2");
        repeat (4) @(posedge clk);
        check("done_count2", 32'(done_cnt), 32'd1);
        check("done_time2", 32'(done_cyc - start_cyc), 32'(EXP_DONE));
        check("frame_count2", 32'(rx_q.size()), 32'(NF));
        if (rx_q.size() == NF) begin
            check("d2_frame1", 32'(rx_q[0]), 32'h41);
            check("d2_frame4", 32'(rx_q[3]), 32'h4F);
            check("d2_frame5", 32'(rx_q[4]), 32'h57);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
